lfsr_stream_decryptor: RTL and testbench

- Hardware decryption stage that consumes the 64-byte encrypted message stream: 7-bit LFSR ciphertext with an even-parity bit in bit 7.
- Recovers the LFSR start state and which of the 9 legal tap patterns was used, by exploiting the guaranteed space-character (0x20) preamble of at least 10 bytes.
- Emits plaintext bytes downstream.
- Sits between the data-memory reader (encrypted bytes, addresses 64..127) and the plaintext writer (addresses 0..63); replaces the software search in program 2.

---
 rtl/lfsr_stream_decryptor.sv | 218 +++++++++++++++++++++
 tb/tb_lfsr_stream_decryptor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_decryptor.sv
// LFSR stream decryptor: recovers seed and tap pattern from a space preamble, then emits plaintext.
// Optional PARITY_CHECK_EN adds a saturating parity-error counter output (par_err_cnt).
module lfsr_stream_decryptor #(
    parameter int unsigned MSG_LEN   = 64,
    parameter int unsigned TRAIN_LEN = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       Ack,
    output logic       lock_err,
    output logic [3:0] tap_idx,
    output logic [6:0] lfsr_init
`ifdef PARITY_CHECK_EN
    ,
    output logic [6:0] par_err_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_TRAIN, S_DECODE, S_FLUSH, S_DONE
    } state_t;

    localparam logic [6:0] MSG_END    = 7'(MSG_LEN);
    localparam logic [6:0] TRAIN_LAST = 7'(TRAIN_LEN - 1);
    localparam logic [6:0] SPACE      = 7'h20;

    function automatic logic [6:0] tap_of(input logic [3:0] k);
        case (k)
            4'd0:    return 7'h60;
            4'd1:    return 7'h48;
            4'd2:    return 7'h78;
            4'd3:    return 7'h72;
            4'd4:    return 7'h6A;
            4'd5:    return 7'h69;
            4'd6:    return 7'h5C;
            4'd7:    return 7'h7E;
            default: return 7'h7B;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
        return {s[5:0], ^(s & tap)};
    endfunction

    state_t          state_q, state_d;
    logic [6:0]      byte_cnt_q, byte_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            lock_err_q, lock_err_d;
    logic [3:0]      tap_idx_q, tap_idx_d;
    logic [6:0]      lfsr_init_q, lfsr_init_d;
    logic [8:0][6:0] cand_q, cand_d;
    logic [8:0]      alive_q, alive_d;
    logic [6:0]      work_q, work_d;

    logic            active, out_free, accept;
    logic [6:0]      key_in, ks;
    logic [8:0][6:0] nxt;
    logic [8:0]      match;
    logic [3:0]      low;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        lock_err_d  = lock_err_q;
        tap_idx_d   = tap_idx_q;
        lfsr_init_d = lfsr_init_q;
        cand_d      = cand_q;
        alive_d     = alive_q;
        work_d      = work_q;
        nxt         = '0;
        match       = '0;
        low         = 4'hF;

        active   = (state_q == S_SEED) || (state_q == S_TRAIN) ||
                   (state_q == S_DECODE) || (state_q == S_FLUSH);
        out_free = !out_valid_q || out_ready;
        // The counter stop keeps DECODE from taking a 65th byte while the last output drains.
        in_ready = active && out_free && (byte_cnt_q != MSG_END);
        accept   = in_valid && in_ready;
        key_in   = in_data[6:0] ^ SPACE;
        ks       = lfsr_step(work_q, tap_of(tap_idx_q));

        for (int unsigned k = 0; k < 9; k++) begin
            nxt[k]   = lfsr_step(cand_q[k], tap_of(4'(k)));
            match[k] = alive_q[k] && (nxt[k] == key_in);
        end
        for (int unsigned k = 0; k < 9; k++) begin
            if (match[8 - k]) low = 4'(8 - k);
        end

        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) byte_cnt_d = byte_cnt_q + 7'd1;

        case (state_q)
            S_IDLE: begin
                byte_cnt_d  = '0;
                lock_err_d  = 1'b0;
                tap_idx_d   = 4'hF;
                out_valid_d = 1'b0;
                if (!Start) state_d = S_SEED;
            end
            S_SEED: begin
                if (accept) begin
                    if (key_in == '0) begin
                        lock_err_d = 1'b1;
                        state_d    = S_FLUSH;
                    end else begin
                        for (int unsigned k = 0; k < 9; k++) cand_d[k] = key_in;
                        alive_d     = '1;
                        lfsr_init_d = key_in;
                        out_valid_d = 1'b1;
                        out_data_d  = {1'b0, SPACE};
                        state_d     = S_TRAIN;
                    end
                end
            end
            S_TRAIN: begin
                if (accept) begin
                    cand_d  = nxt;
                    alive_d = match;
                    if (match == '0) begin
                        lock_err_d = 1'b1;
                        state_d    = S_FLUSH;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = {1'b0, SPACE};
                        if (byte_cnt_q == TRAIN_LAST) begin
                            tap_idx_d = low;
                            work_d    = nxt[low];
                            state_d   = S_DECODE;
                        end
                    end
                end
            end
            S_DECODE: begin
                if (accept) begin
                    work_d      = ks;
                    out_valid_d = 1'b1;
                    out_data_d  = {1'b0, in_data[6:0] ^ ks};
                end
                if (byte_cnt_q == MSG_END && out_free) state_d = S_DONE;
            end
            S_FLUSH: begin
                if (byte_cnt_d == MSG_END) state_d = S_DONE;
            end
            default: ;
        endcase

        if (Start && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            lock_err_q  <= 1'b0;
            tap_idx_q   <= 4'hF;
            lfsr_init_q <= '0;
            cand_q      <= '0;
            alive_q     <= '0;
            work_q      <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            lock_err_q  <= lock_err_d;
            tap_idx_q   <= tap_idx_d;
            lfsr_init_q <= lfsr_init_d;
            cand_q      <= cand_d;
            alive_q     <= alive_d;
            work_q      <= work_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign Ack       = (state_q == S_DONE);
    assign lock_err  = lock_err_q;
    assign tap_idx   = tap_idx_q;
    assign lfsr_init = lfsr_init_q;

`ifdef PARITY_CHECK_EN
    logic [6:0] par_cnt_q, par_cnt_d;

    always_comb begin
        par_cnt_d = par_cnt_q;
        if (state_q == S_IDLE) begin
            par_cnt_d = '0;
        end else if (accept && (in_data[7] != ^in_data[6:0]) && par_cnt_q != 7'h7F) begin
            par_cnt_d = par_cnt_q + 7'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) par_cnt_q <= '0;
        else       par_cnt_q <= par_cnt_d;
    end

    assign par_err_cnt = par_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_stream_decryptor.sv
// Randomized bench for lfsr_stream_decryptor against a keystream-level reference model.
module tb_lfsr_stream_decryptor;

    localparam int MSG   = 64;
    localparam int TRAIN = 10;
    localparam logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    logic       Clk = 1'b0;
    logic       Reset, Start, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, Ack, lock_err;
    logic [7:0] out_data;
    logic [3:0] tap_idx;
    logic [6:0] lfsr_init;
`ifdef PARITY_CHECK_EN
    logic [6:0] par_err_cnt;
`endif

    lfsr_stream_decryptor #(.MSG_LEN(MSG), .TRAIN_LEN(TRAIN)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .Ack(Ack), .lock_err(lock_err), .tap_idx(tap_idx), .lfsr_init(lfsr_init)
`ifdef PARITY_CHECK_EN
        , .par_err_cnt(par_err_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] msg_pt [MSG];
    logic [7:0] msg_ct [MSG];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Feedback is the parity of the tapped bits, appended below the shifted state.
    function automatic logic [6:0] nx(input logic [6:0] s, input logic [6:0] t);
        int fb;
        fb = $countones(s & t) % 2;
        return 7'((int'(s) * 2 + fb) % 128);
    endfunction

    function automatic int first_miss(input int k, input logic [6:0] seed);
        logic [6:0] s;
        s = seed;
        for (int i = 1; i < TRAIN; i++) begin
            s = nx(s, TAPS[k]);
            if ((msg_ct[i][6:0] ^ 7'h20) != s) return i;
        end
        return TRAIN;
    endfunction

    task automatic build_expect(output int tapk, output int fail_at, output logic [6:0] seed);
        logic [6:0] s;
        int fm;
        exp_q.delete();
        seed    = msg_ct[0][6:0] ^ 7'h20;
        tapk    = -1;
        fail_at = 0;
        if (seed == 0) return;
        for (int k = 0; k < 9; k++) begin
            fm = first_miss(k, seed);
            if (fm == TRAIN && tapk < 0) tapk = k;
            if (fm > fail_at) fail_at = fm;
        end
        if (tapk < 0) begin
            for (int i = 0; i < fail_at; i++) exp_q.push_back(8'h20);
            return;
        end
        s = seed;
        for (int i = 0; i < MSG; i++) begin
            if (i > 0) s = nx(s, TAPS[tapk]);
            if (i < TRAIN) exp_q.push_back(8'h20);
            else           exp_q.push_back({1'b0, msg_ct[i][6:0] ^ s});
        end
    endtask

    task automatic run_msg(input int tk, input logic [6:0] init, input int pre, input int joke_mode,
                           input int corrupt, input int rdy_pct, input int abort_at,
                           input int reset_at, input int par_flip);
        string      joke;
        logic [6:0] s, c, seed;
        int         tapk, fail_at, sent, cyc, nmis;
        logic       stall_prev;
        logic [7:0] data_prev;
        joke = "A joke is a very serious thing.";
        for (int i = 0; i < MSG; i++) begin
            if (i < pre) msg_pt[i] = 8'h20;
            else if (joke_mode != 0 && (i - pre) < joke.len()) msg_pt[i] = joke[i - pre];
            else msg_pt[i] = 8'($urandom_range(126, 33));
        end
        s = init;
        for (int i = 0; i < MSG; i++) begin
            c = msg_pt[i][6:0] ^ s;
            msg_ct[i] = {1'($countones(c) % 2), c};
            s = nx(s, TAPS[tk]);
        end
        if (corrupt != 0) begin
            for (int x = 1; x < 128; x++) begin
                msg_ct[5] = msg_ct[5] ^ 8'(x);
                build_expect(tapk, fail_at, seed);
                if (tapk < 0 && fail_at == 5) break;
                msg_ct[5] = msg_ct[5] ^ 8'(x);
            end
        end
        if (par_flip != 0) begin
            msg_ct[3]  = msg_ct[3] ^ 8'h80;
            msg_ct[40] = msg_ct[40] ^ 8'h80;
        end
        build_expect(tapk, fail_at, seed);
        got_q.delete();
        sent = 0;
        cyc = 0;
        stall_prev = 1'b0;
        data_prev = '0;

        @(negedge Clk);
        Start = 1'b0;
        while (cyc < 3000) begin
            @(negedge Clk);
            cyc++;
            in_valid  = (sent < MSG);
            in_data   = (sent < MSG) ? msg_ct[sent] : 8'h00;
            out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (Ack) break;
            if (stall_prev) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_data", out_data, data_prev);
            end
            if (out_valid && !out_ready) check_eq("ready_gate", in_ready, 0);
            if (out_valid && out_ready) begin
                if (got_q.size() < exp_q.size()) check_eq("data", out_data, exp_q[got_q.size()]);
                else check_eq("extra_out", got_q.size(), exp_q.size());
                got_q.push_back(out_data);
            end
            if (in_valid && in_ready) sent++;
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
            if (abort_at >= 0 && sent == abort_at) begin
                @(negedge Clk);
                Start = 1'b1;
                in_valid = 1'b0;
                out_ready = 1'b0;
                @(negedge Clk);
                #1;
                check_eq("abort_in_ready", in_ready, 0);
                check_eq("abort_out_valid", out_valid, 0);
                check_eq("abort_ack", Ack, 0);
                return;
            end
            if (reset_at >= 0 && sent == reset_at) begin
                #2;
                Reset = 1'b1;
                #1;
                check_eq("rst_out_valid", out_valid, 0);
                check_eq("rst_out_data", out_data, 0);
                check_eq("rst_tap_idx", tap_idx, 4'hF);
                check_eq("rst_lfsr_init", lfsr_init, 0);
                check_eq("rst_lock_err", lock_err, 0);
                check_eq("rst_ack", Ack, 0);
                check_eq("rst_in_ready", in_ready, 0);
                Start = 1'b1;
                in_valid = 1'b0;
                @(negedge Clk);
                Reset = 1'b0;
                return;
            end
        end

        check_eq("ack_seen", Ack, 1);
        check_eq("out_count", got_q.size(), exp_q.size());
        check_eq("accepts", sent, MSG);
        check_eq("tap_idx", tap_idx, (tapk < 0) ? 15 : tapk);
        check_eq("lock_err", lock_err, (tapk < 0) ? 1 : 0);
        check_eq("done_out_valid", out_valid, 0);
        if (seed != 0) check_eq("lfsr_init", lfsr_init, seed);
        if (tapk >= 0) check_eq("tap_not_above_true", (tap_idx <= 4'(tk)), 1);
        if (tapk == tk) begin
            nmis = 0;
            foreach (got_q[i]) if (got_q[i] !== msg_pt[i]) nmis++;
            check_eq("plain_match", nmis, 0);
        end
`ifdef PARITY_CHECK_EN
        check_eq("par_err_cnt", par_err_cnt, (par_flip != 0) ? 2 : 0);
`endif
        @(negedge Clk);
        Start = 1'b1;
        in_valid = 1'b0;
        @(negedge Clk);
        #1;
        check_eq("idle_ack", Ack, 0);
    endtask

    initial begin
        logic [6:0] inits [3];
        inits = '{7'h01, 7'h7F, 7'h2B};
        Reset = 1'b1;
        Start = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        #12;
        check_eq("reset_in_ready", in_ready, 0);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_out_data", out_data, 0);
        check_eq("reset_ack", Ack, 0);
        check_eq("reset_lock_err", lock_err, 0);
        check_eq("reset_tap_idx", tap_idx, 4'hF);
        check_eq("reset_lfsr_init", lfsr_init, 0);
        @(negedge Clk);
        Reset = 1'b0;

        run_msg(3, 7'h3A, 13, 1, 0, 100, -1, -1, 0);
        for (int t = 0; t < 9; t++)
            for (int j = 0; j < 3; j++)
                run_msg(t, inits[j], 10, 0, 0, 100, -1, -1, 0);
        for (int r = 0; r < 3; r++)
            run_msg(int'($urandom_range(8)), 7'($urandom_range(127, 1)), 10, 0, 0, 50, -1, -1, 0);
        run_msg(4, 7'h55, 10, 0, 1, 70, -1, -1, 0);
        run_msg(2, 7'h00, 10, 0, 0, 100, -1, -1, 0);
        run_msg(6, 7'h11, 10, 0, 0, 100, 30, -1, 0);
        run_msg(6, 7'h11, 10, 0, 0, 100, -1, -1, 0);
        run_msg(1, 7'h4C, 10, 0, 0, 80, -1, 30, 0);
        run_msg(8, 7'h23, 10, 0, 0, 100, -1, -1, 0);
`ifdef PARITY_CHECK_EN
        run_msg(5, 7'h3C, 10, 0, 0, 60, -1, -1, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
